// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared types and helpers for the round-robin N:1 mux.
//   out_state_e : output register state (StEmpty / StFull)
//   idx_width() : channel index width for a given channel count
//   DefWidth/DefN : default data width and channel count
package rr_mux_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefN     = 4;

    typedef enum logic {
        StEmpty,
        StFull
    } out_state_e;

    // Never returns 0 so index vectors stay legal even for degenerate N.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter holding the priority pointer.
//   i_clk      : clock, rising edge
//   i_reset    : synchronous active-high reset (pointer -> 0)
//   i_req      : N-bit request vector
//   i_advance  : pulse on a transfer; pointer moves to one past the granted channel
//   o_gnt      : one-hot grant (combinational)
//   o_gnt_idx  : index of the granted channel
//   o_any      : at least one request present
module rr_arbiter
    import rr_mux_pkg::*;
#(
    parameter  int unsigned N  = DefN,
    localparam int unsigned SW = idx_width(N)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [N-1:0]  i_req,
    input  logic          i_advance,
    output logic [N-1:0]  o_gnt,
    output logic [SW-1:0] o_gnt_idx,
    output logic          o_any
);

    logic [SW-1:0] r_ptr;
    logic [SW-1:0] w_idx;
    logic          w_found;

    assign o_any = |i_req;

    // Scan from the pointer upwards with wrap; first requester wins.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int unsigned off = 0; off < N; off++) begin
            w_idx = SW'((32'(r_ptr) + off) % N);
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_gnt_idx    = w_idx;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_gnt_idx == SW'(N - 1)) ? '0 : o_gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/rr_mux_n.sv
// rr_mux_n: N:1 mux with per-channel valid/ready, round-robin arbitration and a
// registered 1-entry output stage.
//   i_clk, i_reset        : clock; synchronous active-high reset
//   i_in_data/i_in_valid  : channel i word at [i*WIDTH +: WIDTH]
//   o_in_ready            : channel i word accepted this cycle (at most one bit)
//   o_out_data/o_out_src  : registered selected word and its channel index
//   o_out_valid/i_out_ready : output handshake
//   i_sel_force_en/i_sel_force : only when RR_MUX_SEL_OVERRIDE_EN is defined;
//                           restricts eligibility to one channel, pointer untouched
module rr_mux_n
    import rr_mux_pkg::*;
#(
    parameter  int unsigned WIDTH = DefWidth,
    parameter  int unsigned N     = DefN,
    localparam int unsigned SW    = idx_width(N)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [N*WIDTH-1:0] i_in_data,
    input  logic [N-1:0]       i_in_valid,
    output logic [N-1:0]       o_in_ready,
    output logic [WIDTH-1:0]   o_out_data,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [SW-1:0]      o_out_src
`ifdef RR_MUX_SEL_OVERRIDE_EN
    ,
    input  logic               i_sel_force_en,
    input  logic [SW-1:0]      i_sel_force
`endif
);

    out_state_e       r_state;
    logic [WIDTH-1:0] r_data;
    logic [SW-1:0]    r_src;

    logic [N-1:0]     w_elig;
    logic [N-1:0]     w_gnt;
    logic [SW-1:0]    w_gnt_idx;
    logic             w_any;
    logic             w_forced;
    logic             w_can_accept;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;

`ifdef RR_MUX_SEL_OVERRIDE_EN
    // Out-of-range force index leaves nothing eligible.
    always_comb begin
        w_elig = '0;
        if (i_sel_force_en) begin
            if (32'(i_sel_force) < N) begin
                w_elig[i_sel_force] = i_in_valid[i_sel_force];
            end
        end else begin
            w_elig = i_in_valid;
        end
    end
    assign w_forced = i_sel_force_en;
`else
    assign w_elig   = i_in_valid;
    assign w_forced = 1'b0;
`endif

    rr_arbiter #(
        .N (N)
    ) u_arbiter (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_req     (w_elig),
        .i_advance (w_xfer & ~w_forced),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    assign w_can_accept = (r_state == StEmpty) | i_out_ready;
    // Reset gates acceptance so no word is handshaken away during reset.
    assign w_xfer       = ~i_reset & w_can_accept & w_any;
    assign o_in_ready   = {N{w_xfer}} & w_gnt;
    assign w_sel_data   = i_in_data[w_gnt_idx*WIDTH +: WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StEmpty;
            r_data  <= '0;
            r_src   <= '0;
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_xfer) begin
                        r_state <= StFull;
                        r_data  <= w_sel_data;
                        r_src   <= w_gnt_idx;
                    end
                end
                StFull: begin
                    // Drain and refill in the same cycle keeps the stage full.
                    if (w_xfer) begin
                        r_data <= w_sel_data;
                        r_src  <= w_gnt_idx;
                    end else if (i_out_ready) begin
                        r_state <= StEmpty;
                    end
                end
                default: r_state <= StEmpty;
            endcase
        end
    end

    assign o_out_valid = (r_state == StFull);
    assign o_out_data  = r_data;
    assign o_out_src   = r_src;

endmodule
